// File: rtl/control.sv
// Shift-and-add multiplier controller: sequences load, add and shift, then pulses done.
// Optional state output is enabled by defining CONTROL_STATE_PORT_EN.
module control (
  input  logic       clk,
  input  logic       rst,
  input  logic       st,
  input  logic       M,
  input  logic       K,
  output logic       idle,
  output logic       done,
  output logic       load,
  output logic       sh,
`ifdef CONTROL_STATE_PORT_EN
  output logic [1:0] state,
`endif
  output logic       ad
);

  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b01;
  localparam logic [1:0] S2 = 2'b10;
  localparam logic [1:0] S3 = 2'b11;

  logic [1:0] state_q;
  logic [1:0] state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S0: if (st) state_d = S1;
      S1: begin
        if (M)      state_d = S2;
        else if (K) state_d = S3;
      end
      S2: state_d = K ? S3 : S1;
      S3: state_d = S0;
      default: state_d = S0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S0;
    else     state_q <= state_d;
  end

  // Mealy outputs; reset overrides the current state so nothing fires while rst is held.
  always_comb begin
    idle = 1'b1;
    load = 1'b0;
    ad   = 1'b0;
    sh   = 1'b0;
    done = 1'b0;
    if (!rst) begin
      idle = (state_q == S0);
      load = (state_q == S0) & st;
      ad   = (state_q == S1) & M;
      sh   = ((state_q == S1) & ~M) | (state_q == S2);
      done = (state_q == S3);
    end
  end

`ifdef CONTROL_STATE_PORT_EN
  assign state = state_q;
`endif

endmodule

// File: tb/tb_control.sv
// Scoreboard bench for the multiplier controller: stimulus queues expected outputs, a monitor checks them.
module tb_control;

  logic       clk = 1'b0;
  logic       rst, st, m, k;
  logic       idle, done, load, sh, ad;
`ifdef CONTROL_STATE_PORT_EN
  logic [1:0] state;
`endif

  typedef struct {
    logic [4:0] outs;
    logic [1:0] state;
    bit         chk_state;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   assertions = 0;
  int   failures   = 0;

  localparam logic [4:0] O_IDLE = 5'b10000;
  localparam logic [4:0] O_LOAD = 5'b11000;
  localparam logic [4:0] O_AD   = 5'b00100;
  localparam logic [4:0] O_SH   = 5'b00010;
  localparam logic [4:0] O_DONE = 5'b00001;

  control dut (
    .clk  (clk),
    .rst  (rst),
    .st   (st),
    .M    (m),
    .K    (k),
    .idle (idle),
    .done (done),
    .load (load),
    .sh   (sh),
`ifdef CONTROL_STATE_PORT_EN
    .state(state),
`endif
    .ad   (ad)
  );

  always #5 clk = ~clk;

  // One cycle per call: drive inputs just after the edge and queue the outputs expected this cycle.
  task automatic applyStimulus(input logic r, input logic s, input logic mi, input logic ki,
                               input logic [4:0] e_outs, input logic [1:0] e_state,
                               input bit chk, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; st = s; m = mi; k = ki;
    e.outs = e_outs; e.state = e_state; e.chk_state = chk; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [4:0] got;
    got = {idle, load, ad, sh, done};
    assertions++;
    if (got !== e.outs) begin
      failures++;
      $display("[TB] FAIL %s outputs{idle,load,ad,sh,done} got=%b expected=%b", e.name, got, e.outs);
    end
`ifdef CONTROL_STATE_PORT_EN
    if (e.chk_state) begin
      assertions++;
      if (state !== e.state) begin
        failures++;
        $display("[TB] FAIL %s state got=%b expected=%b", e.name, state, e.state);
      end
    end
`endif
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin : stimulus
    rst = 1'b1; st = 1'b0; m = 1'b0; k = 1'b0;

    // reset, then quiet idle with K toggling to show it has no effect in S0
    applyStimulus(1, 0, 0, 0, O_IDLE, 2'b00, 0, "reset_hold");
    applyStimulus(0, 0, 0, 0, O_IDLE, 2'b00, 1, "idle1");
    applyStimulus(0, 0, 0, 1, O_IDLE, 2'b00, 1, "idle2_k");
    applyStimulus(0, 0, 1, 0, O_IDLE, 2'b00, 1, "idle3");

    // add, shift, loop back, shift, done
    applyStimulus(0, 1, 0, 0, O_LOAD, 2'b00, 1, "a_load");
    applyStimulus(0, 0, 1, 0, O_AD,   2'b01, 1, "a_add");
    applyStimulus(0, 0, 0, 0, O_SH,   2'b10, 1, "a_shift");
    applyStimulus(0, 0, 0, 1, O_SH,   2'b01, 1, "a_shift_last");
    applyStimulus(0, 0, 0, 0, O_DONE, 2'b11, 1, "a_done");
    applyStimulus(0, 0, 0, 0, O_IDLE, 2'b00, 1, "a_idle");

    // S2 exits to done when K=1
    applyStimulus(0, 1, 0, 0, O_LOAD, 2'b00, 1, "b_load");
    applyStimulus(0, 0, 1, 1, O_AD,   2'b01, 1, "b_add");
    applyStimulus(0, 0, 0, 1, O_SH,   2'b10, 1, "b_shift_last");
    applyStimulus(0, 0, 0, 0, O_DONE, 2'b11, 1, "b_done");

    // zero bits stay in S1 until K
    applyStimulus(0, 1, 0, 0, O_LOAD, 2'b00, 1, "c_load");
    applyStimulus(0, 0, 0, 0, O_SH,   2'b01, 1, "c_sh0");
    applyStimulus(0, 0, 0, 0, O_SH,   2'b01, 1, "c_sh1");
    applyStimulus(0, 0, 0, 1, O_SH,   2'b01, 1, "c_sh_last");
    applyStimulus(0, 0, 0, 1, O_DONE, 2'b11, 1, "c_done_k");
    applyStimulus(0, 0, 0, 0, O_IDLE, 2'b00, 1, "c_idle");

    // st held high throughout an operation is ignored outside S0
    applyStimulus(0, 1, 0, 0, O_LOAD, 2'b00, 1, "d_load");
    applyStimulus(0, 1, 1, 0, O_AD,   2'b01, 1, "d_add_st");
    applyStimulus(0, 1, 0, 0, O_SH,   2'b10, 1, "d_shift_st");
    applyStimulus(0, 1, 0, 1, O_SH,   2'b01, 1, "d_shift_last_st");
    applyStimulus(0, 1, 0, 0, O_DONE, 2'b11, 1, "d_done_st");
    applyStimulus(0, 0, 0, 0, O_IDLE, 2'b00, 1, "d_idle");

    // reset in S2 aborts without a done pulse
    applyStimulus(0, 1, 0, 0, O_LOAD, 2'b00, 1, "e_load");
    applyStimulus(0, 0, 1, 0, O_AD,   2'b01, 1, "e_add");
    applyStimulus(1, 1, 1, 1, O_IDLE, 2'b10, 1, "e_rst_in_s2");
    applyStimulus(0, 0, 0, 0, O_IDLE, 2'b00, 1, "e_after_rst");
    applyStimulus(0, 0, 0, 1, O_IDLE, 2'b00, 1, "e_no_done");

    // reset while st is high overrides load
    applyStimulus(1, 1, 0, 0, O_IDLE, 2'b00, 1, "f_rst_st");
    applyStimulus(0, 0, 0, 0, O_IDLE, 2'b00, 1, "f_idle");

    repeat (2) @(posedge clk);
    assertions++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
